// File: rtl/baud_gen_prog_if.sv
// Control and strobe bundle between a UART and its baud generator.
// The i_frac field exists only when BAUD_FRAC_EN is defined.
interface baud_gen_prog_if #(
    parameter int DIV_W = 16
);
    logic             i_en;
    logic [DIV_W-1:0] i_div;
    logic             i_div_load;
`ifdef BAUD_FRAC_EN
    logic [3:0]       i_frac;
`endif
    logic             i_tx_sync;
    logic             rx_enb;
    logic             tx_enb;
    logic             o_div_err;

    modport master (
        output i_en, i_div, i_div_load, i_tx_sync,
`ifdef BAUD_FRAC_EN
        output i_frac,
`endif
        input  rx_enb, tx_enb, o_div_err
    );

    modport slave (
        input  i_en, i_div, i_div_load, i_tx_sync,
`ifdef BAUD_FRAC_EN
        input  i_frac,
`endif
        output rx_enb, tx_enb, o_div_err
    );
endinterface

// File: rtl/baud_gen_prog.sv
// Programmable rx/tx baud strobe generator with shadowed divisor loads and tx re-sync.
// Define BAUD_FRAC_EN to add the 4-bit fractional divisor and its accumulator.
module baud_gen_prog #(
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 326
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    baud_gen_prog_if.slave  bus
);
    localparam int OS_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_shd;
    logic             pend;
    logic [DIV_W-1:0] rx_cnt;
    logic [OS_W-1:0]  os_cnt;
    logic             rx_enb_q;
    logic             tx_enb_q;
    logic             div_err_q;

    logic             load_ok;
    logic [DIV_W-1:0] div_shd_nx;
    logic             pend_nx;
    logic [DIV_W-1:0] wrap_val;
    logic             wrap;
    logic             apply;

    assign load_ok    = bus.i_div_load && (bus.i_div != '0);
    assign div_shd_nx = load_ok ? bus.i_div : div_shd;
    assign pend_nx    = load_ok || pend;

`ifdef BAUD_FRAC_EN
    logic [3:0] frac_act;
    logic [3:0] frac_shd;
    logic [3:0] frac_acc;
    logic       ext;
    logic [3:0] frac_shd_nx;
    logic [3:0] frac_act_nx;
    logic [4:0] frac_sum;

    assign frac_shd_nx = load_ok ? bus.i_frac : frac_shd;
    assign frac_act_nx = apply ? frac_shd_nx : frac_act;
    assign frac_sum    = {1'b0, frac_acc} + {1'b0, frac_act_nx};
    // A carry out of the accumulator stretches the following period by one cycle.
    assign wrap_val    = div_act - DIV_W'(1) + {{(DIV_W-1){1'b0}}, ext};
`else
    assign wrap_val    = div_act - DIV_W'(1);
`endif

    assign wrap  = (rx_cnt == wrap_val);
    // Pending divisors only land on a period boundary, so no period is ever cut short.
    assign apply = pend_nx && (!bus.i_en || bus.i_tx_sync || wrap);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            div_act   <= DIV_W'(DEFAULT_DIV);
            div_shd   <= DIV_W'(DEFAULT_DIV);
            pend      <= 1'b0;
            rx_cnt    <= '0;
            os_cnt    <= '0;
            rx_enb_q  <= 1'b0;
            tx_enb_q  <= 1'b0;
            div_err_q <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_act  <= '0;
            frac_shd  <= '0;
            frac_acc  <= '0;
            ext       <= 1'b0;
`endif
        end else begin
            div_err_q <= bus.i_div_load && (bus.i_div == '0);
            div_shd   <= div_shd_nx;
            pend      <= pend_nx && !apply;
            if (apply) begin
                div_act <= div_shd_nx;
            end
`ifdef BAUD_FRAC_EN
            frac_shd <= frac_shd_nx;
            frac_act <= frac_act_nx;
`endif
            if (bus.i_tx_sync || !bus.i_en) begin
                rx_cnt   <= '0;
                os_cnt   <= '0;
                rx_enb_q <= 1'b0;
                tx_enb_q <= 1'b0;
`ifdef BAUD_FRAC_EN
                frac_acc <= '0;
                ext      <= 1'b0;
`endif
            end else if (wrap) begin
                rx_cnt   <= '0;
                rx_enb_q <= 1'b1;
                if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
                    os_cnt   <= '0;
                    tx_enb_q <= 1'b1;
                end else begin
                    os_cnt   <= os_cnt + OS_W'(1);
                    tx_enb_q <= 1'b0;
                end
`ifdef BAUD_FRAC_EN
                frac_acc <= frac_sum[3:0];
                ext      <= frac_sum[4];
`endif
            end else begin
                rx_cnt   <= rx_cnt + DIV_W'(1);
                rx_enb_q <= 1'b0;
                tx_enb_q <= 1'b0;
            end
        end
    end

    assign bus.rx_enb    = rx_enb_q;
    assign bus.tx_enb    = tx_enb_q;
    assign bus.o_div_err = div_err_q;
endmodule

// File: doc/baud_gen_prog.md
# baud_gen_prog

Programmable, parametrised baud-rate enable generator for the UART. It produces a one-cycle `rx_enb` oversampling strobe and a `tx_enb` bit strobe derived from the same counter chain, so that tx is exactly OVERSAMPLE × rx. It adds three things a fixed-count generator lacks: a divisor loadable at run time without glitches, tx phase re-alignment, and an optional fractional divisor. It sits between the system clock and the UART tx/rx state machines.

## Interface
- `DIV_W`, default 16: width of the rx divisor.
- `OVERSAMPLE`, default 16: rx ticks per tx tick; legal range 2..64.
- `DEFAULT_DIV`, default 326: active divisor after reset (50 MHz, 9600 baud, ×16); must be ≥ 1.
- `i_clk`  in  1  single system clock; all logic on its rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  run enable; low holds all counters at 0.
- `i_div`  in  DIV_W  new divisor value, in rx clock cycles.
- `i_div_load`  in  1  one-cycle strobe that captures `i_div` (and `i_frac` when configured).
- `i_frac`  in  4  fractional divisor in 1/16 cycle units. Present only with `BAUD_FRAC_EN`.
- `i_tx_sync`  in  1  one-cycle strobe that restarts the rx and oversample counters.
- `rx_enb`  out  1  registered one-cycle rx oversample strobe.
- `tx_enb`  out  1  registered one-cycle tx bit strobe.
- `o_div_err`  out  1  registered one-cycle pulse: a load was rejected.

## Operation
- State: `div_act` (active divisor), `div_shd` plus a `pend` flag (shadowed load), `rx_cnt` (DIV_W bits), `os_cnt` (clog2(OVERSAMPLE) bits), `frac_acc` (4 bits, `BAUD_FRAC_EN` only).
- Reset values:
  - `rx_enb` = 0, `tx_enb` = 0, `o_div_err` = 0.
  - `rx_cnt` = 0, `os_cnt` = 0, `pend` = 0, `frac_acc` = 0.
  - `div_act` = DEFAULT_DIV; active fraction = 0.
- rx counting, while `i_en` = 1:
  - If `rx_cnt` == `div_act` − 1 (the wrap), `rx_cnt` ← 0 and `rx_enb` ← 1.
  - Otherwise `rx_cnt` increments and `rx_enb` ← 0.
- tx counting: on each rx wrap, `os_cnt` increments. If `os_cnt` == OVERSAMPLE − 1, `os_cnt` ← 0 and `tx_enb` ← 1 in the same cycle as that `rx_enb`. Otherwise `tx_enb` ← 0.
- `i_en` = 0: `rx_cnt`, `os_cnt` and `frac_acc` are cleared; no strobes are issued. Divisor loads are still accepted.
- Divisor load:
  - `i_div_load` with `i_div` ≠ 0 sets `div_shd` and `pend`.
  - The pending value moves to `div_act` at the next rx wrap, or immediately if `i_en` = 0. A period is never truncated or stretched mid-count.
  - `i_div` = 0 is rejected: `o_div_err` pulses for one cycle and the state is unchanged.
  - A second load before the pending one applies overwrites `div_shd`.
- `i_tx_sync`:
  - `rx_cnt` ← 0, `os_cnt` ← 0, `frac_acc` ← 0.
  - Any pending divisor is applied in the same cycle.
  - No strobe is issued in that cycle, even if a wrap coincides. `i_tx_sync` has priority over the wrap.
- Divisor 1: `rx_enb` is held high continuously, and `tx_enb` fires every OVERSAMPLE cycles.
- Asynchronous reset mid-count returns everything to the reset values immediately. Counting restarts on the first enabled edge after release.

## Timing
- Divisor D, enabled continuously: `rx_enb` is high for one cycle every D cycles. The first `rx_enb` is visible in the cycle after the D-th enabled rising edge.
- `tx_enb` period is exactly OVERSAMPLE × D cycles and is always coincident with an `rx_enb`.
- `i_tx_sync` sampled on edge N: the next `rx_enb` follows edge N+D, and the next `tx_enb` follows edge N + OVERSAMPLE·D.
- A load accepted while running takes effect on the period that starts after the current wrap.
- `o_div_err` is high in the cycle after the rejected strobe.

## Configuration
- `BAUD_FRAC_EN` defined:
  - The `i_frac` port and a 4-bit `frac_acc` are present.
  - At each rx wrap, `frac_acc` ← `frac_acc` + frac. On carry-out, the next rx period is D+1 cycles.
  - Mean rx period is D + frac/16. The fraction is captured and applied together with `i_div`.
- `BAUD_FRAC_EN` undefined: no `i_frac` port, no accumulator, integer divisor only.

## Test plan
- Reset release, `i_en` = 1, default divisor 326, OVERSAMPLE = 16 -> `rx_enb` every 326 cycles, `tx_enb` every 5216 cycles, each `tx_enb` coincident with an `rx_enb`.
- Load 100 while running at 326, mid-period -> the current period still completes at 326, then `rx_enb` every 100 cycles.
- Load 0 -> `o_div_err` pulses once, divisor unchanged, strobe spacing undisturbed.
- `i_tx_sync` on the same edge as an rx wrap -> no strobe that cycle, next `rx_enb` after D cycles, next `tx_enb` after 16·D cycles.
- `i_rst_n` asserted mid-count, then `i_en` toggled low and back high -> all outputs 0 immediately, no strobes while disabled, first `rx_enb` D cycles after re-enable.
- `BAUD_FRAC_EN`, D = 10, frac = 8 -> rx periods alternate 10/11 cycles, giving 168 cycles per 16 `rx_enb`.
